// File: rtl/prime_count_responder.sv
// Prime counter behind a req/busy call handshake. Counts the primes between 2
// and a captured limit by trial division, using repeated subtraction for the
// remainder so that no divider is needed.
module prime_count_responder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_req,
  output logic             run_busy,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] field_prime_count_output,
  output logic [WIDTH-1:0] field_last_prime_output,
  output logic             field_finish_flag_output
);

  typedef enum logic [2:0] {
    IDLE,
    N_START,
    D_CHECK,
    SUB,
    PRIME,
    COMPOSITE,
    DONE
  } state_t;

  localparam logic [WIDTH:0]   ONE_N = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   TWO_N = {{(WIDTH-1){1'b0}}, 2'd2};
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_next;

  // n carries one extra bit so that a limit of all-ones still terminates.
  logic [WIDTH-1:0]   lim;
  logic [WIDTH:0]     n;
  logic [WIDTH:0]     d;
  logic [WIDTH:0]     r;
  logic [1:0]         rst_sync;
  logic [2*WIDTH+1:0] d_sq;
  logic [2*WIDTH+1:0] n_wide;
  logic               n_over;

  assign d_sq   = {{(WIDTH+1){1'b0}}, d} * {{(WIDTH+1){1'b0}}, d};
  assign n_wide = {{(WIDTH+1){1'b0}}, n};
  assign n_over = n > {1'b0, lim};

  // Two-flop release of the async reset; no call is accepted until it settles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decision for the search loop.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (run_req && rst_sync[1]) state_next = N_START;
      N_START:   state_next = n_over ? DONE : D_CHECK;
      D_CHECK:   state_next = (d_sq > n_wide) ? PRIME : SUB;
      SUB: begin
        if (r >= d)        state_next = SUB;
        else if (r == '0)  state_next = COMPOSITE;
        else               state_next = D_CHECK;
      end
      PRIME:     state_next = N_START;
      COMPOSITE: state_next = N_START;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs, updated according to the current state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lim                      <= '0;
      n                        <= '0;
      d                        <= '0;
      r                        <= '0;
      run_busy                 <= 1'b0;
      field_prime_count_output <= '0;
      field_last_prime_output  <= '0;
      field_finish_flag_output <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run_req && rst_sync[1]) begin
            lim                      <= limit;
            n                        <= TWO_N;
            field_prime_count_output <= '0;
            field_last_prime_output  <= '0;
            field_finish_flag_output <= 1'b0;
            run_busy                 <= 1'b1;
          end
        end
        N_START: begin
          if (!n_over) d <= TWO_N;
        end
        D_CHECK: begin
          if (d_sq <= n_wide) r <= n;
        end
        SUB: begin
          if (r >= d)        r <= r - d;
          else if (r != '0)  d <= d + ONE_N;
        end
        PRIME: begin
          field_prime_count_output <= field_prime_count_output + ONE_W;
          field_last_prime_output  <= n[WIDTH-1:0];
          n                        <= n + ONE_N;
        end
        COMPOSITE: begin
          n <= n + ONE_N;
        end
        DONE: begin
          field_finish_flag_output <= 1'b1;
          run_busy                 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_count_responder.sv
// Directed testbench for prime_count_responder: hand-computed prime counts for
// several limits, handshake corner cases, mid-run reset and an 8-bit full-range run.
module tb_prime_count_responder;

  logic        clk;
  logic        reset;
  logic        run_req;
  logic [15:0] limit;
  logic        run_busy;
  logic [15:0] prime_count;
  logic [15:0] last_prime;
  logic        finish_flag;

  logic        run_req8;
  logic [7:0]  limit8;
  logic        run_busy8;
  logic [7:0]  prime_count8;
  logic [7:0]  last_prime8;
  logic        finish_flag8;

  int check_count;
  int fail_count;
  int excl_violations;
  int busy_cycles;
  int timed_out;

  prime_count_responder #(.WIDTH(16)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .run_req                  (run_req),
    .run_busy                 (run_busy),
    .limit                    (limit),
    .field_prime_count_output (prime_count),
    .field_last_prime_output  (last_prime),
    .field_finish_flag_output (finish_flag)
  );

  prime_count_responder #(.WIDTH(8)) dut8 (
    .clk                      (clk),
    .reset                    (reset),
    .run_req                  (run_req8),
    .run_busy                 (run_busy8),
    .limit                    (limit8),
    .field_prime_count_output (prime_count8),
    .field_last_prime_output  (last_prime8),
    .field_finish_flag_output (finish_flag8)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Busy and finish must never be seen together on either instance.
  always @(negedge clk) begin
    if ((run_busy && finish_flag) || (run_busy8 && finish_flag8))
      excl_violations = excl_violations + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count = check_count + 1;
    if (observed !== expected) begin
      fail_count = fail_count + 1;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One-cycle run_req pulse on the 16-bit instance with the given limit.
  task automatic applyStimulus(input logic [15:0] lim);
    @(negedge clk);
    limit   = lim;
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
  endtask

  // Wait for finish on the 16-bit instance, counting busy cycles on the way.
  task automatic waitDone(input string tag, input int budget);
    int cycles;
    cycles      = 0;
    timed_out   = 0;
    busy_cycles = run_busy ? 1 : 0;
    while (1) begin
      @(negedge clk);
      if (finish_flag) break;
      if (run_busy) busy_cycles = busy_cycles + 1;
      cycles = cycles + 1;
      if (cycles >= budget) begin
        timed_out = 1;
        break;
      end
    end
    checkOutput({tag, "_timeout"}, timed_out, 0);
  endtask

  initial begin
    check_count     = 0;
    fail_count      = 0;
    excl_violations = 0;
    reset    = 1'b0;
    run_req  = 1'b0;
    limit    = '0;
    run_req8 = 1'b0;
    limit8   = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",   run_busy,    0);
    checkOutput("rst_count",  prime_count, 0);
    checkOutput("rst_last",   last_prime,  0);
    checkOutput("rst_finish", finish_flag, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // limit=10: busy rises on the accepting edge, 4 primes, last 7.
    applyStimulus(16'd10);
    checkOutput("l10_busy_rise", run_busy, 1);
    waitDone("l10", 5000);
    checkOutput("l10_busy", run_busy,    0);
    checkOutput("l10_count", prime_count, 4);
    checkOutput("l10_last",  last_prime,  7);

    // limit=100: 25 primes, last 97, finish sticky while idle.
    applyStimulus(16'd100);
    waitDone("l100", 20000);
    checkOutput("l100_count", prime_count, 25);
    checkOutput("l100_last",  last_prime,  97);
    checkOutput("l100_finish", finish_flag, 1);
    repeat (5) @(negedge clk);
    checkOutput("l100_finish_hold", finish_flag, 1);
    checkOutput("l100_busy_hold",   run_busy,    0);

    // Back-to-back limit=1 then limit=2.
    applyStimulus(16'd1);
    waitDone("l1", 100);
    checkOutput("l1_busy_cycles", busy_cycles, 2);
    checkOutput("l1_count", prime_count, 0);
    checkOutput("l1_last",  last_prime,  0);
    applyStimulus(16'd2);
    waitDone("l2", 100);
    checkOutput("l2_count", prime_count, 1);
    checkOutput("l2_last",  last_prime,  2);

    // limit=50 with a limit change and a run_req pulse while busy.
    applyStimulus(16'd50);
    repeat (5) @(negedge clk);
    limit   = 16'd5;
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    waitDone("l50", 10000);
    checkOutput("l50_count", prime_count, 15);
    checkOutput("l50_last",  last_prime,  47);
    repeat (3) @(negedge clk);
    checkOutput("l50_no_restart", run_busy, 0);

    // run_req held high: a new call starts right after finish and clears it.
    @(negedge clk);
    limit   = 16'd1;
    run_req = 1'b1;
    @(negedge clk);
    waitDone("hold", 100);
    @(negedge clk);
    checkOutput("hold_restart_busy",   run_busy,    1);
    checkOutput("hold_restart_finish", finish_flag, 0);
    run_req = 1'b0;
    waitDone("hold_end", 100);

    // Reset mid-run clears everything at once and stays idle afterwards.
    applyStimulus(16'd100);
    repeat (200) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_busy",   run_busy,    0);
    checkOutput("mid_rst_count",  prime_count, 0);
    checkOutput("mid_rst_last",   last_prime,  0);
    checkOutput("mid_rst_finish", finish_flag, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("post_rst_busy",   run_busy,    0);
    checkOutput("post_rst_finish", finish_flag, 0);
    applyStimulus(16'd10);
    waitDone("post_rst_l10", 5000);
    checkOutput("post_rst_count", prime_count, 4);
    checkOutput("post_rst_last",  last_prime,  7);

    // 8-bit instance, full-range limit.
    @(negedge clk);
    limit8   = 8'd255;
    run_req8 = 1'b1;
    @(negedge clk);
    run_req8 = 1'b0;
    timed_out = 0;
    for (int c = 0; c < 90000; c++) begin
      @(negedge clk);
      if (finish_flag8) break;
      if (c == 89999) timed_out = 1;
    end
    checkOutput("w8_timeout", timed_out, 0);
    checkOutput("w8_count", prime_count8, 54);
    checkOutput("w8_last",  last_prime8,  251);
    checkOutput("w8_busy",  run_busy8,    0);

    checkOutput("busy_finish_excl", excl_violations, 0);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
